// File: rtl/bp_commit_trace_tx.sv
// ---------------------------------------------------------------------------
// bp_commit_trace_tx
//
// Packs per-core commit, writeback and trap events into 32-bit flits on a
// valid/ready link. A host-side receiver uses the stream to drive Dromajo
// cosimulation. Late writebacks are paired with their commits. Every captured
// event, including one that is dropped, takes a 16-bit sequence number. This
// lets the receiver detect lost events.
//
// Ports
//   clk_i, reset_i         clock, asynchronous active-low reset
//   en_i                   accept new events and writebacks
//   hartid_i               hart id placed in each header (sampled at launch)
//   commit_*               commit event: pc, instr, writeback kind
//   interrupt_v_i/cause_i  trap event (squashes a same-cycle commit)
//   iwb_* / fwb_*          integer / FP writeback (addr, data)
//   flit_o/flit_v_o        flit stream out
//   flit_ready_i           receiver ready
//   overflow_o             sticky: an event or writeback was dropped
//   busy_o                 a queue is non-empty or a packet is in flight
//
// Packet formats
//   commit: HDR, PC_LO, PC_HI, INSTR [, DATA_LO, DATA_HI if wbkind != none]
//   trap  : HDR, CAUSE_LO, CAUSE_HI
//   HDR   : [31:30] type (01 commit, 10 trap), [29:28] wbkind, [27:23] rd,
//           [22:16] hartid, [15:0] seq
// ---------------------------------------------------------------------------

// Small circular FIFO with combinational head read. The launch decision
// needs the head entry in the same cycle.
// Ports: push_i/data_i write (caller never pushes when full), pop_i
// removes the head (caller never pops when empty), data_o is the head entry,
// empty_o/full_o give the occupancy.
module bp_commit_trace_fifo #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               push_i,
  input  logic [width_p-1:0] data_i,
  input  logic               pop_i,
  output logic [width_p-1:0] data_o,
  output logic               empty_o,
  output logic               full_o
);

  localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w = $clog2(els_p + 1);

  logic [width_p-1:0] mem [els_p];
  logic [ptr_w-1:0]   wr_ptr_reg;
  logic [ptr_w-1:0]   rd_ptr_reg;
  logic [cnt_w-1:0]   cnt_reg;

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(els_p - 1)) ? '0 : p + ptr_w'(1);
  endfunction

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (push_i) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop_i)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push_i, pop_i})
        2'b10:   cnt_reg <= cnt_reg + cnt_w'(1);
        2'b01:   cnt_reg <= cnt_reg - cnt_w'(1);
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr_reg] <= data_i;
  end

  assign data_o  = mem[rd_ptr_reg];
  assign empty_o = (cnt_reg == '0);
  assign full_o  = (cnt_reg == cnt_w'(els_p));

endmodule

module bp_commit_trace_tx #(
  parameter int vaddr_width_p = 39,
  parameter int cmt_els_p     = 8,
  parameter int wb_els_p      = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     en_i,
  input  logic [6:0]               hartid_i,
  input  logic                     commit_v_i,
  input  logic [vaddr_width_p-1:0] commit_pc_i,
  input  logic [31:0]              commit_instr_i,
  input  logic                     commit_iwb_i,
  input  logic                     commit_fwb_i,
  input  logic                     interrupt_v_i,
  input  logic [63:0]              cause_i,
  input  logic                     iwb_v_i,
  input  logic [4:0]               iwb_addr_i,
  input  logic [63:0]              iwb_data_i,
  input  logic                     fwb_v_i,
  input  logic [4:0]               fwb_addr_i,
  input  logic [63:0]              fwb_data_i,
  output logic [31:0]              flit_o,
  output logic                     flit_v_o,
  input  logic                     flit_ready_i,
  output logic                     overflow_o,
  output logic                     busy_o
);

  localparam logic [1:0] wb_none = 2'b00;
  localparam logic [1:0] wb_int  = 2'b01;
  localparam logic [1:0] wb_fp   = 2'b10;

  // For a trap, val holds the cause. For a commit, val holds the
  // sign-extended PC. The 64-bit field is needed for either one.
  typedef struct packed {
    logic        trap;
    logic [1:0]  wbk;
    logic [15:0] seq;
    logic [63:0] val;
    logic [31:0] instr;
  } rec_s;

  typedef struct packed {
    logic [4:0]  addr;
    logic [63:0] data;
  } wb_s;

  typedef enum logic [3:0] {
    IDLE, HDR, PC_LO, PC_HI, INSTR, DATA_LO, DATA_HI, CAUSE_LO, CAUSE_HI
  } state_e;

  state_e state_reg, state_next;

  logic [15:0] seq_reg;
  logic        overflow_reg;

  logic [31:0] pkt_hdr_reg;
  logic [63:0] pkt_val_reg;
  logic [31:0] pkt_instr_reg;
  logic [63:0] pkt_data_reg;
  logic        pkt_trap_reg;
  logic [1:0]  pkt_wbk_reg;

  // ------------------------------------------------------------------
  // Event capture
  // ------------------------------------------------------------------
  logic                     event_v;
  logic                     drop_v;
  logic [63:0]              pc_sext;
  rec_s                     rec_in;
  logic [$bits(rec_s)-1:0]  rec_head_raw;
  rec_s                     rec_head;
  logic                     rec_push, rec_pop, rec_empty, rec_full;

  wb_s                      iwb_in, fwb_in, iwb_head, fwb_head;
  logic [$bits(wb_s)-1:0]   iwb_head_raw, fwb_head_raw;
  logic                     iwb_push, iwb_pop, iwb_empty, iwb_full;
  logic                     fwb_push, fwb_pop, fwb_empty, fwb_full;

  assign pc_sext = {{(64 - vaddr_width_p){commit_pc_i[vaddr_width_p-1]}}, commit_pc_i};

  // A trap squashes a same-cycle commit. Only one record per cycle.
  assign event_v  = en_i & (interrupt_v_i | commit_v_i);
  assign rec_push = event_v & ~rec_full;

  always_comb begin
    rec_in     = '0;
    rec_in.seq = seq_reg;
    if (interrupt_v_i) begin
      rec_in.trap = 1'b1;
      rec_in.val  = cause_i;
    end else begin
      rec_in.val   = pc_sext;
      rec_in.instr = commit_instr_i;
      rec_in.wbk   = commit_iwb_i ? wb_int : (commit_fwb_i ? wb_fp : wb_none);
    end
  end

  assign iwb_in   = {iwb_addr_i, iwb_data_i};
  assign fwb_in   = {fwb_addr_i, fwb_data_i};
  assign iwb_push = en_i & iwb_v_i & ~iwb_full;
  assign fwb_push = en_i & fwb_v_i & ~fwb_full;

  // Fullness is judged on the occupancy before this edge. A push into a
  // full queue is dropped, even if the head leaves in the same cycle.
  assign drop_v = (event_v & rec_full)
                | (en_i & iwb_v_i & iwb_full)
                | (en_i & fwb_v_i & fwb_full);

  // The sequence number advances on every captured event. This includes
  // dropped events, so the receiver sees a gap.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      seq_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (event_v) seq_reg      <= seq_reg + 16'd1;
      if (drop_v)  overflow_reg <= 1'b1;
    end
  end

  bp_commit_trace_fifo #(.width_p($bits(rec_s)), .els_p(cmt_els_p)) rec_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (rec_push),
    .data_i  (rec_in),
    .pop_i   (rec_pop),
    .data_o  (rec_head_raw),
    .empty_o (rec_empty),
    .full_o  (rec_full)
  );

  bp_commit_trace_fifo #(.width_p($bits(wb_s)), .els_p(wb_els_p)) iwb_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (iwb_push),
    .data_i  (iwb_in),
    .pop_i   (iwb_pop),
    .data_o  (iwb_head_raw),
    .empty_o (iwb_empty),
    .full_o  (iwb_full)
  );

  bp_commit_trace_fifo #(.width_p($bits(wb_s)), .els_p(wb_els_p)) fwb_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (fwb_push),
    .data_i  (fwb_in),
    .pop_i   (fwb_pop),
    .data_o  (fwb_head_raw),
    .empty_o (fwb_empty),
    .full_o  (fwb_full)
  );

  assign rec_head = rec_head_raw;
  assign iwb_head = iwb_head_raw;
  assign fwb_head = fwb_head_raw;

  // ------------------------------------------------------------------
  // Launch
  // ------------------------------------------------------------------
  logic        head_ready;
  logic        last_flit;
  logic        handshake;
  logic        launch;
  logic [4:0]  launch_rd;
  logic [63:0] launch_data;
  logic [31:0] launch_hdr;

  // Records leave in strict order. A commit whose writeback has not
  // arrived yet holds back every record behind it.
  always_comb begin
    head_ready = 1'b0;
    if (!rec_empty) begin
      if (rec_head.trap) begin
        head_ready = 1'b1;
      end else begin
        case (rec_head.wbk)
          wb_int:  head_ready = ~iwb_empty;
          wb_fp:   head_ready = ~fwb_empty;
          default: head_ready = 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    last_flit = 1'b0;
    case (state_reg)
      INSTR:             last_flit = (pkt_wbk_reg == wb_none);
      DATA_HI, CAUSE_HI: last_flit = 1'b1;
      default:           last_flit = 1'b0;
    endcase
  end

  assign flit_v_o  = (state_reg != IDLE);
  assign handshake = flit_v_o & flit_ready_i;

  // Launch can also happen on the last handshake of a packet. The next
  // header then follows with no idle cycle.
  assign launch  = head_ready & ((state_reg == IDLE) | (handshake & last_flit));
  assign rec_pop = launch;
  assign iwb_pop = launch & ~rec_head.trap & (rec_head.wbk == wb_int);
  assign fwb_pop = launch & ~rec_head.trap & (rec_head.wbk == wb_fp);

  always_comb begin
    launch_rd   = '0;
    launch_data = '0;
    launch_hdr  = '0;
    if (rec_head.trap) begin
      launch_hdr = {2'b10, wb_none, 5'd0, hartid_i, rec_head.seq};
    end else begin
      case (rec_head.wbk)
        wb_int: begin
          launch_rd   = iwb_head.addr;
          launch_data = iwb_head.data;
        end
        wb_fp: begin
          launch_rd   = fwb_head.addr;
          launch_data = fwb_head.data;
        end
        default: begin
          launch_rd   = '0;
          launch_data = '0;
        end
      endcase
      launch_hdr = {2'b01, rec_head.wbk, launch_rd, hartid_i, rec_head.seq};
    end
  end

  // The packet register changes only at launch. Launch happens only in
  // IDLE or on the final handshake, so flit_o stays stable during a stall.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      pkt_hdr_reg   <= '0;
      pkt_val_reg   <= '0;
      pkt_instr_reg <= '0;
      pkt_data_reg  <= '0;
      pkt_trap_reg  <= 1'b0;
      pkt_wbk_reg   <= wb_none;
    end else if (launch) begin
      pkt_hdr_reg   <= launch_hdr;
      pkt_val_reg   <= rec_head.val;
      pkt_instr_reg <= rec_head.instr;
      pkt_data_reg  <= launch_data;
      pkt_trap_reg  <= rec_head.trap;
      pkt_wbk_reg   <= rec_head.trap ? wb_none : rec_head.wbk;
    end
  end

  // ------------------------------------------------------------------
  // Flit FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    flit_o     = '0;
    case (state_reg)
      IDLE: begin
        if (launch) state_next = HDR;
      end
      HDR: begin
        flit_o = pkt_hdr_reg;
        if (handshake) state_next = pkt_trap_reg ? CAUSE_LO : PC_LO;
      end
      PC_LO: begin
        flit_o = pkt_val_reg[31:0];
        if (handshake) state_next = PC_HI;
      end
      PC_HI: begin
        flit_o = pkt_val_reg[63:32];
        if (handshake) state_next = INSTR;
      end
      INSTR: begin
        flit_o = pkt_instr_reg;
        if (handshake) begin
          if (pkt_wbk_reg != wb_none) state_next = DATA_LO;
          else                        state_next = launch ? HDR : IDLE;
        end
      end
      DATA_LO: begin
        flit_o = pkt_data_reg[31:0];
        if (handshake) state_next = DATA_HI;
      end
      DATA_HI: begin
        flit_o = pkt_data_reg[63:32];
        if (handshake) state_next = launch ? HDR : IDLE;
      end
      CAUSE_LO: begin
        flit_o = pkt_val_reg[31:0];
        if (handshake) state_next = CAUSE_HI;
      end
      CAUSE_HI: begin
        flit_o = pkt_val_reg[63:32];
        if (handshake) state_next = launch ? HDR : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign overflow_o = overflow_reg;
  assign busy_o     = ~rec_empty | ~iwb_empty | ~fwb_empty | (state_reg != IDLE);

endmodule

// File: tb/tb_bp_commit_trace_tx.sv
module tb_bp_commit_trace_tx;

  localparam int VA  = 39;
  localparam int CMT = 8;
  localparam int WB  = 4;

  logic          clk_i;
  logic          reset_i;
  logic          en_i;
  logic [6:0]    hartid_i;
  logic          commit_v_i;
  logic [VA-1:0] commit_pc_i;
  logic [31:0]   commit_instr_i;
  logic          commit_iwb_i;
  logic          commit_fwb_i;
  logic          interrupt_v_i;
  logic [63:0]   cause_i;
  logic          iwb_v_i;
  logic [4:0]    iwb_addr_i;
  logic [63:0]   iwb_data_i;
  logic          fwb_v_i;
  logic [4:0]    fwb_addr_i;
  logic [63:0]   fwb_data_i;
  logic [31:0]   flit_o;
  logic          flit_v_o;
  logic          flit_ready_i;
  logic          overflow_o;
  logic          busy_o;

  bp_commit_trace_tx #(.vaddr_width_p(VA), .cmt_els_p(CMT), .wb_els_p(WB)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .en_i           (en_i),
    .hartid_i       (hartid_i),
    .commit_v_i     (commit_v_i),
    .commit_pc_i    (commit_pc_i),
    .commit_instr_i (commit_instr_i),
    .commit_iwb_i   (commit_iwb_i),
    .commit_fwb_i   (commit_fwb_i),
    .interrupt_v_i  (interrupt_v_i),
    .cause_i        (cause_i),
    .iwb_v_i        (iwb_v_i),
    .iwb_addr_i     (iwb_addr_i),
    .iwb_data_i     (iwb_data_i),
    .fwb_v_i        (fwb_v_i),
    .fwb_addr_i     (fwb_addr_i),
    .fwb_data_i     (fwb_data_i),
    .flit_o         (flit_o),
    .flit_v_o       (flit_v_o),
    .flit_ready_i   (flit_ready_i),
    .overflow_o     (overflow_o),
    .busy_o         (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference model: pending records and writebacks as queues. The packet
  // in flight is simply the list of flits it still has to send.
  typedef struct packed {
    logic        trap;
    logic [1:0]  wbk;
    logic [15:0] seq;
    logic [63:0] val;
    logic [31:0] instr;
  } rec_t;

  rec_t        m_rec[$];
  logic [68:0] m_iwb[$];
  logic [68:0] m_fwb[$];
  logic [31:0] m_flits[$];
  logic [15:0] m_seq;
  logic        m_ovf;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk_bit(input string tag, input logic got, input logic exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, got, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_rec.delete();
    m_iwb.delete();
    m_fwb.delete();
    m_flits.delete();
    m_seq = '0;
    m_ovf = 1'b0;
  endtask

  // One clock edge of the reference model, using the inputs as they are now.
  task automatic model_step();
    int          n_rec, n_iwb, n_fwb;
    logic        may_launch;
    rec_t        r;
    logic [68:0] wb;
    n_rec = m_rec.size();
    n_iwb = m_iwb.size();
    n_fwb = m_fwb.size();
    may_launch = (m_flits.size() == 0) || (m_flits.size() == 1 && flit_ready_i);
    if (m_flits.size() != 0 && flit_ready_i) void'(m_flits.pop_front());
    if (may_launch && n_rec != 0) begin
      r = m_rec[0];
      if (r.trap) begin
        void'(m_rec.pop_front());
        m_flits.push_back({2'b10, 2'b00, 5'd0, hartid_i, r.seq});
        m_flits.push_back(r.val[31:0]);
        m_flits.push_back(r.val[63:32]);
      end else if (r.wbk == 2'd0 || (r.wbk == 2'd1 && n_iwb != 0) || (r.wbk == 2'd2 && n_fwb != 0)) begin
        void'(m_rec.pop_front());
        wb = '0;
        if (r.wbk == 2'd1) wb = m_iwb.pop_front();
        else if (r.wbk == 2'd2) wb = m_fwb.pop_front();
        m_flits.push_back({2'b01, r.wbk, wb[68:64], hartid_i, r.seq});
        m_flits.push_back(r.val[31:0]);
        m_flits.push_back(r.val[63:32]);
        m_flits.push_back(r.instr);
        if (r.wbk != 2'd0) begin
          m_flits.push_back(wb[31:0]);
          m_flits.push_back(wb[63:32]);
        end
      end
    end
    if (en_i) begin
      if (interrupt_v_i || commit_v_i) begin
        r = '0;
        r.seq = m_seq;
        if (interrupt_v_i) begin
          r.trap = 1'b1;
          r.val  = cause_i;
        end else begin
          r.val   = {{(64 - VA){commit_pc_i[VA-1]}}, commit_pc_i};
          r.instr = commit_instr_i;
          r.wbk   = commit_iwb_i ? 2'd1 : (commit_fwb_i ? 2'd2 : 2'd0);
        end
        if (n_rec < CMT) m_rec.push_back(r);
        else m_ovf = 1'b1;
        m_seq = m_seq + 16'd1;
      end
      if (iwb_v_i) begin
        if (n_iwb < WB) m_iwb.push_back({iwb_addr_i, iwb_data_i});
        else m_ovf = 1'b1;
      end
      if (fwb_v_i) begin
        if (n_fwb < WB) m_fwb.push_back({fwb_addr_i, fwb_data_i});
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    logic exp_busy;
    exp_busy = (m_rec.size() != 0) || (m_iwb.size() != 0) ||
               (m_fwb.size() != 0) || (m_flits.size() != 0);
    chk_bit("flit_v", flit_v_o, m_flits.size() != 0);
    if (m_flits.size() != 0) chk_word("flit", flit_o, m_flits[0]);
    chk_bit("overflow", overflow_o, m_ovf);
    chk_bit("busy", busy_o, exp_busy);
  endtask

  task automatic step_cycle();
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
    check_outputs();
  endtask

  task automatic clear_events();
    commit_v_i    = 1'b0;
    commit_iwb_i  = 1'b0;
    commit_fwb_i  = 1'b0;
    interrupt_v_i = 1'b0;
    iwb_v_i       = 1'b0;
    fwb_v_i       = 1'b0;
  endtask

  task automatic set_commit(input logic [VA-1:0] pc, input logic [31:0] instr, input logic [1:0] kind);
    commit_v_i     = 1'b1;
    commit_pc_i    = pc;
    commit_instr_i = instr;
    commit_iwb_i   = (kind == 2'd1);
    commit_fwb_i   = (kind == 2'd2);
  endtask

  // Reset is applied between clock edges to exercise its asynchronous path.
  task automatic do_reset();
    #2;
    reset_i = 1'b0;
    #1;
    chk_bit("rst_flit_v", flit_v_o, 1'b0);
    chk_bit("rst_overflow", overflow_o, 1'b0);
    chk_bit("rst_busy", busy_o, 1'b0);
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
  endtask

  initial begin
    int k;
    reset_i        = 1'b0;
    en_i           = 1'b1;
    hartid_i       = 7'd3;
    flit_ready_i   = 1'b1;
    commit_pc_i    = '0;
    commit_instr_i = '0;
    cause_i        = '0;
    iwb_addr_i     = '0;
    iwb_data_i     = '0;
    fwb_addr_i     = '0;
    fwb_data_i     = '0;
    clear_events();
    do_reset();
    check_outputs();

    // 1: single commit, no writeback; header two cycles after capture
    set_commit(39'h0080000000, 32'h00000013, 2'd0);
    step_cycle();
    clear_events();
    chk_bit("t1_no_hdr_t1", flit_v_o, 1'b0);
    step_cycle();
    chk_bit("t1_hdr_v", flit_v_o, 1'b1);
    chk_word("t1_hdr", flit_o, 32'h40030000);
    step_cycle();
    chk_word("t1_pc_lo", flit_o, 32'h80000000);
    step_cycle();
    chk_word("t1_pc_hi", flit_o, 32'h00000000);
    step_cycle();
    chk_word("t1_instr", flit_o, 32'h00000013);
    step_cycle();

    // 2: int-writeback commit, writeback arrives 5 cycles later
    set_commit(39'h0080000004, 32'h00A00513, 2'd1);
    step_cycle();
    clear_events();
    repeat (5) step_cycle();
    chk_bit("t2_wait_wb", flit_v_o, 1'b0);
    iwb_v_i    = 1'b1;
    iwb_addr_i = 5'd10;
    iwb_data_i = 64'hDEADBEEF01234567;
    step_cycle();
    clear_events();
    step_cycle();
    chk_word("t2_hdr", flit_o, 32'h55030001);
    repeat (4) step_cycle();
    chk_word("t2_data_lo", flit_o, 32'h01234567);
    step_cycle();
    chk_word("t2_data_hi", flit_o, 32'hDEADBEEF);
    step_cycle();

    // 3: trap together with a commit; only the trap is captured
    set_commit(39'h0080000008, 32'h00000073, 2'd0);
    interrupt_v_i = 1'b1;
    cause_i       = 64'h8000000000000007;
    step_cycle();
    clear_events();
    step_cycle();
    chk_word("t3_hdr", flit_o, 32'h80030002);
    step_cycle();
    chk_word("t3_cause_lo", flit_o, 32'h00000007);
    step_cycle();
    chk_word("t3_cause_hi", flit_o, 32'h80000000);
    step_cycle();

    // 4: negative PC, then a second commit sent back-to-back
    set_commit(39'h7FFFFFF000, 32'h00000013, 2'd0);
    step_cycle();
    set_commit(39'h0000001000, 32'h00100093, 2'd0);
    step_cycle();
    clear_events();
    chk_word("t4_hdr_a", flit_o, 32'h40030003);
    step_cycle();
    chk_word("t4_pc_lo", flit_o, 32'hFFFFF000);
    step_cycle();
    chk_word("t4_pc_hi", flit_o, 32'hFFFFFFFF);
    step_cycle();
    chk_word("t4_instr", flit_o, 32'h00000013);
    step_cycle();
    chk_bit("t4_b2b_v", flit_v_o, 1'b1);
    chk_word("t4_hdr_b", flit_o, 32'h40030004);
    repeat (4) step_cycle();

    // 5: ten commits with the receiver stalled; the last one overflows
    flit_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_commit(39'h0080001000 + 39'(4 * i), $urandom(), 2'd0);
      step_cycle();
    end
    clear_events();
    chk_bit("t5_overflow", overflow_o, 1'b1);
    chk_word("t5_hdr", flit_o, 32'h40030005);
    repeat (3) begin
      step_cycle();
      chk_word("t5_hold", flit_o, 32'h40030005);
    end
    flit_ready_i = 1'b1;
    repeat (2) step_cycle();
    flit_ready_i = 1'b0;
    repeat (3) step_cycle();
    flit_ready_i = 1'b1;
    repeat (45) step_cycle();
    set_commit(39'h0080002000, 32'h00000013, 2'd0);
    step_cycle();
    clear_events();
    step_cycle();
    chk_word("t5_seq_after_drop", flit_o, 32'h4003000F);
    repeat (4) step_cycle();

    // 6: reset while PC_HI is on the link
    set_commit(39'h0080003000, 32'h00000013, 2'd0);
    step_cycle();
    clear_events();
    repeat (3) step_cycle();
    chk_bit("t6_pre_v", flit_v_o, 1'b1);
    do_reset();
    set_commit(39'h0080004000, 32'h00000013, 2'd0);
    step_cycle();
    clear_events();
    step_cycle();
    chk_word("t6_hdr_seq0", flit_o, 32'h40030000);
    chk_bit("t6_overflow_clr", overflow_o, 1'b0);
    repeat (4) step_cycle();

    // Random traffic checked against the model every cycle
    for (int i = 0; i < 2500; i++) begin
      en_i         = ($urandom_range(99) < 92);
      flit_ready_i = ($urandom_range(99) < 70);
      if ($urandom_range(99) < 3) hartid_i = 7'($urandom());
      k = $urandom_range(2);
      commit_v_i     = ($urandom_range(99) < 30);
      commit_iwb_i   = (k == 1);
      commit_fwb_i   = (k == 2);
      commit_pc_i    = VA'({$urandom(), $urandom()});
      commit_instr_i = $urandom();
      interrupt_v_i  = ($urandom_range(99) < 4);
      cause_i        = {$urandom(), $urandom()};
      iwb_v_i        = ($urandom_range(99) < 20);
      iwb_addr_i     = 5'($urandom());
      iwb_data_i     = {$urandom(), $urandom()};
      fwb_v_i        = ($urandom_range(99) < 12);
      fwb_addr_i     = 5'($urandom());
      fwb_data_i     = {$urandom(), $urandom()};
      step_cycle();
    end

    // Drain: no new events, writebacks keep coming so waiting commits finish
    clear_events();
    en_i         = 1'b1;
    flit_ready_i = 1'b1;
    for (int i = 0; i < 300; i++) begin
      iwb_v_i    = ($urandom_range(99) < 30);
      iwb_data_i = {$urandom(), $urandom()};
      fwb_v_i    = ($urandom_range(99) < 30);
      fwb_data_i = {$urandom(), $urandom()};
      step_cycle();
    end
    clear_events();
    repeat (10) step_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
